d_jb_redirect_ctrl: RTL and testbench

//  Decode-stage control-flow sequencer. Consumes decoded jump/branch controls,

---
 rtl/d_jb_redirect_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_d_jb_redirect_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/d_jb_redirect_ctrl.sv
// Decode-stage jump/branch sequencer: waits for branch/jr operands, resolves
// taken/not-taken and issues a registered one-cycle PC redirect, flush and link write.
module d_jb_redirect_ctrl #(
  parameter int DELAY_SLOT = 1,
  parameter int STALL_MAX  = 8,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [1:0]       i_jump,
  input  logic [2:0]       i_bop,
  input  logic             i_link,
  input  logic             i_ops_ready,
  input  logic             i_rs_eq_rt,
  output logic             o_stall,
  output logic             o_pc_load,
  output logic [1:0]       o_pc_sel,
  output logic             o_flush,
  output logic             o_link_we,
  output logic             o_stall_err,
  output logic [CNT_W-1:0] o_taken_cnt,
  output logic [CNT_W-1:0] o_ntaken_cnt
);

  localparam int         SC_W     = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;
  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JMP  = 2'b10;
  localparam logic [1:0] SEL_REG  = 2'b11;
  localparam logic       FLUSH_ON = (DELAY_SLOT == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_REDIR = 2'b10
  } state_t;

  state_t            state_r, state_s;
  logic              pc_load_r, flush_r, link_we_r, stall_err_r;
  logic [1:0]        pc_sel_r;
  logic [1:0]        pend_sel_r;
  logic              pend_bne_r;
  logic [SC_W-1:0]   stall_cnt_r;
  logic [CNT_W-1:0]  taken_cnt_r, ntaken_cnt_r;

  logic              is_j_s, is_jr_s, is_beq_s, is_bne_s, ctrl_s;
  logic [1:0]        dec_sel_s;
  logic              dec_bne_s;
  logic              stall_s, resolve_s, latch_s, err_set_s, sc_inc_s, sc_clr_s;
  logic [1:0]        res_sel_s;
  logic              res_bne_s, res_link_s, taken_s, ntaken_s;

  // Instruction decode; a jump overrides any branch opcode present alongside it.
  always_comb begin
    is_j_s    = (i_jump == 2'b01);
    is_jr_s   = (i_jump == 2'b10);
    is_beq_s  = (i_bop == 3'b001);
    is_bne_s  = (i_bop == 3'b010);
    ctrl_s    = i_valid & (is_j_s | is_jr_s | is_beq_s | is_bne_s);
    dec_bne_s = ~is_j_s & ~is_jr_s & is_bne_s;
    if (is_j_s) begin
      dec_sel_s = SEL_JMP;
    end else if (is_jr_s) begin
      dec_sel_s = SEL_REG;
    end else begin
      dec_sel_s = SEL_BR;
    end
  end

  // Next-state, stall and resolve decisions.
  always_comb begin
    state_s    = state_r;
    stall_s    = 1'b0;
    resolve_s  = 1'b0;
    latch_s    = 1'b0;
    err_set_s  = 1'b0;
    sc_inc_s   = 1'b0;
    sc_clr_s   = 1'b0;
    res_sel_s  = SEL_IDLE;
    res_bne_s  = 1'b0;
    res_link_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (ctrl_s) begin
          if (~is_j_s & ~i_ops_ready) begin
            stall_s = 1'b1;
            latch_s = 1'b1;
            state_s = ST_STALL;
          end else begin
            resolve_s  = 1'b1;
            res_sel_s  = dec_sel_s;
            res_bne_s  = dec_bne_s;
            res_link_s = is_j_s & i_link;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STALL: begin
        if (i_ops_ready) begin
          resolve_s = 1'b1;
          res_sel_s = pend_sel_r;
          res_bne_s = pend_bne_r;
          sc_clr_s  = 1'b1;
          state_s   = ST_RUN;
        end else if (stall_cnt_r == SC_W'(STALL_MAX - 1)) begin
          // Abandon the wait: release decode so the pipeline is not held forever.
          err_set_s = 1'b1;
          sc_clr_s  = 1'b1;
          state_s   = ST_RUN;
        end else begin
          stall_s  = 1'b1;
          sc_inc_s = 1'b1;
        end
      end
      ST_REDIR: begin
        state_s = ST_RUN;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
    taken_s  = resolve_s & ((res_sel_s != SEL_BR) | (res_bne_s ^ i_rs_eq_rt));
    ntaken_s = resolve_s & ~taken_s;
    if (taken_s) begin
      state_s = ST_REDIR;
    end else begin
      state_s = state_s;
    end
  end

  // State, registered strobes, pending-instruction capture and counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_RUN;
      pc_load_r    <= 1'b0;
      pc_sel_r     <= SEL_IDLE;
      flush_r      <= 1'b0;
      link_we_r    <= 1'b0;
      stall_err_r  <= 1'b0;
      pend_sel_r   <= SEL_IDLE;
      pend_bne_r   <= 1'b0;
      stall_cnt_r  <= '0;
      taken_cnt_r  <= '0;
      ntaken_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      pc_load_r   <= taken_s;
      pc_sel_r    <= taken_s ? res_sel_s : SEL_IDLE;
      flush_r     <= taken_s & FLUSH_ON;
      link_we_r   <= taken_s & res_link_s;
      stall_err_r <= stall_err_r | err_set_s;
      if (latch_s) begin
        pend_sel_r <= dec_sel_s;
        pend_bne_r <= dec_bne_s;
      end
      if (sc_clr_s) begin
        stall_cnt_r <= '0;
      end else if (sc_inc_s) begin
        stall_cnt_r <= stall_cnt_r + SC_W'(1);
      end
      if (taken_s) begin
        taken_cnt_r <= taken_cnt_r + CNT_W'(1);
      end
      if (ntaken_s) begin
        ntaken_cnt_r <= ntaken_cnt_r + CNT_W'(1);
      end
    end
  end

  assign o_stall      = stall_s;
  assign o_pc_load    = pc_load_r;
  assign o_pc_sel     = pc_sel_r;
  assign o_flush      = flush_r;
  assign o_link_we    = link_we_r;
  assign o_stall_err  = stall_err_r;
  assign o_taken_cnt  = taken_cnt_r;
  assign o_ntaken_cnt = ntaken_cnt_r;

endmodule

// File: tb/tb_d_jb_redirect_ctrl.sv
// Directed bench for d_jb_redirect_ctrl: single-cycle vector table plus
// hand-written stall, abandon, redirect-shadow, reset and counter-wrap sequences.
module tb_d_jb_redirect_ctrl;

  logic        clk, rst, valid, link, ready, eq;
  logic [1:0]  jump;
  logic [2:0]  bop;
  logic        stall, load, flush, lwe, err;
  logic [1:0]  sel;
  logic [15:0] tcnt, ncnt;
  logic        d2_stall, d2_load, d2_flush, d2_lwe, d2_err;
  logic [1:0]  d2_sel, d2_tcnt, d2_ncnt;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_t, exp_n;

  d_jb_redirect_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_jump(jump), .i_bop(bop),
    .i_link(link), .i_ops_ready(ready), .i_rs_eq_rt(eq),
    .o_stall(stall), .o_pc_load(load), .o_pc_sel(sel), .o_flush(flush),
    .o_link_we(lwe), .o_stall_err(err), .o_taken_cnt(tcnt), .o_ntaken_cnt(ncnt)
  );

  d_jb_redirect_ctrl #(.DELAY_SLOT(0), .STALL_MAX(8), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_jump(jump), .i_bop(bop),
    .i_link(link), .i_ops_ready(ready), .i_rs_eq_rt(eq),
    .o_stall(d2_stall), .o_pc_load(d2_load), .o_pc_sel(d2_sel), .o_flush(d2_flush),
    .o_link_we(d2_lwe), .o_stall_err(d2_err), .o_taken_cnt(d2_tcnt), .o_ntaken_cnt(d2_ncnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] jump;
    logic [2:0] bop;
    logic       link;
    logic       eq;
    logic       load;
    logic [1:0] sel;
    logic       lwe;
    logic       nt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    valid = 1'b0; jump = 2'b00; bop = 3'b000; link = 1'b0; ready = 1'b0; eq = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_taken"},     32'(tcnt),    exp_t & 32'hFFFF);
    chk({nm, "_ntaken"},    32'(ncnt),    exp_n & 32'hFFFF);
    chk({nm, "_d2_taken"},  32'(d2_tcnt), exp_t & 32'h3);
    chk({nm, "_d2_ntaken"}, 32'(d2_ncnt), exp_n & 32'h3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_st;
    logic any_load;
    //            valid jump   bop     link  eq    load  sel    lwe   nt
    vecs[0]  = '{1'b1, 2'b01, 3'b000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0}; // jal
    vecs[1]  = '{1'b1, 2'b00, 3'b001, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0}; // beq eq
    vecs[2]  = '{1'b1, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1}; // bne eq
    vecs[3]  = '{1'b1, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1}; // beq ne
    vecs[4]  = '{1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0}; // bne ne
    vecs[5]  = '{1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0}; // jr
    vecs[6]  = '{1'b1, 2'b01, 3'b000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0}; // j
    vecs[7]  = '{1'b1, 2'b01, 3'b001, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0}; // j + beq: jump wins
    vecs[8]  = '{1'b1, 2'b11, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // R-type
    vecs[9]  = '{1'b0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // not valid
    vecs[10] = '{1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // other bop
    vecs[11] = '{1'b1, 2'b01, 3'b010, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0}; // jal + bne

    clk = 1'b0;
    idle_in();
    rst = 1'b1;
    exp_t = 32'd0;
    exp_n = 32'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_load",  32'(load),  32'd0);
    chk("rst_sel",   32'(sel),   32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_lwe",   32'(lwe),   32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk_cnts("rst");

    for (int i = 0; i < 12; i++) begin
      valid = vecs[i].valid; jump = vecs[i].jump; bop = vecs[i].bop;
      link = vecs[i].link; eq = vecs[i].eq; ready = 1'b1;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
      step();
      idle_in();
      if (vecs[i].load) exp_t = exp_t + 32'd1;
      if (vecs[i].nt)   exp_n = exp_n + 32'd1;
      chk($sformatf("v%0d_load", i),     32'(load),     32'(vecs[i].load));
      chk($sformatf("v%0d_sel", i),      32'(sel),      32'(vecs[i].sel));
      chk($sformatf("v%0d_lwe", i),      32'(lwe),      32'(vecs[i].lwe));
      chk($sformatf("v%0d_flush", i),    32'(flush),    32'd0);
      chk($sformatf("v%0d_d2_flush", i), 32'(d2_flush), 32'(vecs[i].load));
      chk_cnts($sformatf("v%0d", i));
      if (vecs[i].load) begin
        step();
        chk($sformatf("v%0d_load_width", i), 32'(load), 32'd0);
        chk($sformatf("v%0d_sel_idle", i),   32'(sel),  32'd0);
      end
    end

    // jr waits three cycles (valid dropped mid-wait), resolves on the fourth
    valid = 1'b1; jump = 2'b10; ready = 1'b0;
    #1; chk("jr_stall_c1", 32'(stall), 32'd1);
    step(); #1; chk("jr_stall_c2", 32'(stall), 32'd1);
    step(); valid = 1'b0; #1; chk("jr_stall_c3", 32'(stall), 32'd1);
    chk("jr_no_early_load", 32'(load), 32'd0);
    step(); valid = 1'b1; ready = 1'b1; #1; chk("jr_stall_c4", 32'(stall), 32'd0);
    step(); idle_in();
    exp_t = exp_t + 32'd1;
    chk("jr_load", 32'(load), 32'd1);
    chk("jr_sel",  32'(sel),  32'd3);
    chk("jr_lwe",  32'(lwe),  32'd0);
    chk_cnts("jr");
    step();

    // beq whose operands never arrive: abandoned after STALL_MAX stall cycles
    valid = 1'b1; bop = 3'b001; ready = 1'b0;
    chk("ab_err_before", 32'(err), 32'd0);
    n_st = 0;
    any_load = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (stall) n_st++;
      else valid = 1'b0;
      step();
      any_load = any_load | load;
    end
    chk("ab_stall_cycles", 32'(n_st), 32'd8);
    chk("ab_err",          32'(err),  32'd1);
    chk("ab_d2_err",       32'(d2_err), 32'd1);
    chk("ab_no_load",      32'(any_load), 32'd0);
    chk_cnts("ab");
    idle_in();

    // jr arriving in the redirect shadow of a j is not treated as control
    valid = 1'b1; jump = 2'b01; ready = 1'b1;
    step();
    jump = 2'b10; ready = 1'b0;
    #1;
    exp_t = exp_t + 32'd1;
    chk("sh_stall", 32'(stall), 32'd0);
    chk("sh_load",  32'(load),  32'd1);
    chk("sh_sel",   32'(sel),   32'd2);
    step();
    idle_in();
    #1;
    chk("sh_load2",  32'(load),  32'd0);
    chk("sh_stall2", 32'(stall), 32'd0);
    chk_cnts("sh");
    step();

    // reset while stalled clears everything, including the sticky error
    valid = 1'b1; bop = 3'b010; ready = 1'b0;
    step();
    step();
    #1; chk("rs_in_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_in();
    exp_t = 32'd0;
    exp_n = 32'd0;
    #1;
    chk("rs_stall", 32'(stall), 32'd0);
    chk("rs_load",  32'(load),  32'd0);
    chk("rs_sel",   32'(sel),   32'd0);
    chk("rs_lwe",   32'(lwe),   32'd0);
    chk("rs_flush", 32'(flush), 32'd0);
    chk("rs_err",   32'(err),   32'd0);
    chk_cnts("rs");

    // five taken jumps: 2-bit counter wraps to 1
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1; jump = 2'b01; ready = 1'b1;
      step();
      idle_in();
      step();
      exp_t = exp_t + 32'd1;
    end
    chk("wr_taken",    32'(tcnt),    32'd5);
    chk("wr_d2_taken", 32'(d2_tcnt), 32'd1);
    chk_cnts("wr");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
